// File: rtl/video_mnist_argmax_decoder.sv
// Argmax decoder: reduces each beat of 10 class scores to (class, score, detect).
// Five-stage comparison tree with a frame-stable threshold carried per beat.
//
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   param_threshold        detect threshold, captured on start-of-frame beats
//   s_axi4s_t*             packed class-score input stream (tuser[0] = SOF)
//   m_axi4s_t*             class index, winning score, detect flag, sideband
module video_mnist_argmax_decoder #(
  parameter int TUSER_WIDTH   = 1,
  parameter int NUM_CLASS     = 10,
  parameter int SCORE_WIDTH   = 8,
  parameter int S_TDATA_WIDTH = NUM_CLASS*SCORE_WIDTH,
  parameter int CLASS_WIDTH   = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [SCORE_WIDTH-1:0]   param_threshold,
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [S_TDATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [CLASS_WIDTH-1:0]   m_axi4s_tclass,
  output logic [SCORE_WIDTH-1:0]   m_axi4s_tscore,
  output logic                     m_axi4s_tdetect,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready
);

  localparam int NP = NUM_CLASS/2;

  typedef struct packed {
    logic [CLASS_WIDTH-1:0] idx;
    logic [SCORE_WIDTH-1:0] sc;
  } cand_t;

  typedef struct packed {
    logic                   v;
    logic [TUSER_WIDTH-1:0] u;
    logic                   l;
    logic [SCORE_WIDTH-1:0] th;
  } side_t;

  // lo always carries the lower class indices, so ties keep lo
  function automatic cand_t pick(input cand_t lo, input cand_t hi);
    return (hi.sc > lo.sc) ? hi : lo;
  endfunction

  function automatic cand_t mk(
    input int                     k,
    input logic [S_TDATA_WIDTH-1:0] d
  );
    cand_t c;
    c.idx = CLASS_WIDTH'(k);
    c.sc  = d[k*SCORE_WIDTH +: SCORE_WIDTH];
    return c;
  endfunction

  logic                   cke;
  logic                   sof_acc;
  logic [SCORE_WIDTH-1:0] thr_q, thr_d;
  logic [SCORE_WIDTH-1:0] thr_beat;

  side_t sd1_q, sd2_q, sd3_q, sd4_q;
  side_t sd1_d;

  cand_t [NP-1:0] c1_q, c1_d;
  cand_t [2:0]    c2_q, c2_d;
  cand_t [1:0]    c3_q, c3_d;
  cand_t          c4_q, c4_d;

  logic                   tv_q, tl_q, td_q;
  logic [TUSER_WIDTH-1:0] tu_q;
  logic [CLASS_WIDTH-1:0] tc_q;
  logic [SCORE_WIDTH-1:0] ts_q;

  assign cke            = !tv_q | m_axi4s_tready;
  assign s_axi4s_tready = cke;
  assign sof_acc        = s_axi4s_tvalid & cke & s_axi4s_tuser[0];

  // An SOF beat uses the value presented with it, not the stale register
  assign thr_beat = s_axi4s_tuser[0] ? param_threshold : thr_q;
  assign thr_d    = sof_acc ? param_threshold : thr_q;

  always_comb begin
    c1_d = '0;
    for (int k = 0; k < NP; k++) begin
      c1_d[k] = pick(mk(2*k, s_axi4s_tdata), mk(2*k+1, s_axi4s_tdata));
    end
    sd1_d.v  = s_axi4s_tvalid;
    sd1_d.u  = s_axi4s_tuser;
    sd1_d.l  = s_axi4s_tlast;
    sd1_d.th = thr_beat;
    c2_d[0] = pick(c1_q[0], c1_q[1]);
    c2_d[1] = pick(c1_q[2], c1_q[3]);
    c2_d[2] = c1_q[4];
    c3_d[0] = pick(c2_q[0], c2_q[1]);
    c3_d[1] = c2_q[2];
    c4_d    = pick(c3_q[0], c3_q[1]);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      thr_q <= '0;
      sd1_q <= '0;
      sd2_q <= '0;
      sd3_q <= '0;
      sd4_q <= '0;
      c1_q  <= '0;
      c2_q  <= '0;
      c3_q  <= '0;
      c4_q  <= '0;
      tv_q  <= 1'b0;
      tu_q  <= '0;
      tl_q  <= 1'b0;
      tc_q  <= '0;
      ts_q  <= '0;
      td_q  <= 1'b0;
    end else begin
      thr_q <= thr_d;
      if (cke) begin
        sd1_q <= sd1_d;
        sd2_q <= sd1_q;
        sd3_q <= sd2_q;
        sd4_q <= sd3_q;
        c1_q  <= c1_d;
        c2_q  <= c2_d;
        c3_q  <= c3_d;
        c4_q  <= c4_d;
        tv_q  <= sd4_q.v;
        tu_q  <= sd4_q.u;
        tl_q  <= sd4_q.l;
        tc_q  <= c4_q.idx;
        ts_q  <= c4_q.sc;
        td_q  <= (c4_q.sc >= sd4_q.th);
      end
    end
  end

  assign m_axi4s_tvalid  = tv_q;
  assign m_axi4s_tuser   = tu_q;
  assign m_axi4s_tlast   = tl_q;
  assign m_axi4s_tclass  = tc_q;
  assign m_axi4s_tscore  = ts_q;
  assign m_axi4s_tdetect = td_q;

endmodule

// File: doc/video_mnist_argmax_decoder.md
# video_mnist_argmax_decoder

Pipelined decoder that consumes the per-pixel class-score stream produced by the MNIST CNN core and reduces each beat to a single class decision. Each input beat carries NUM_CLASS unsigned scores. The block outputs the winning class index, its score and a detect flag derived from a frame-stable threshold. It sits directly downstream of the CNN core's master AXI4-Stream port and feeds the overlay/annotation path.

## Interface
- TUSER_WIDTH, 1, sideband width; bit 0 is start-of-frame.
- NUM_CLASS, 10, number of class scores per beat (fixed at 10 for the tree below).
- SCORE_WIDTH, 8, width of each unsigned class score.
- S_TDATA_WIDTH, NUM_CLASS*SCORE_WIDTH, input data width (80); class k occupies bits [k*SCORE_WIDTH +: SCORE_WIDTH].
- CLASS_WIDTH, 4, width of the class index output.

Ports, clock and reset first:
- aclk  in  1  single clock; all logic is synchronous to its rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- param_threshold  in  SCORE_WIDTH  detect threshold; sampled only on start-of-frame beats.
- s_axi4s_tuser  in  TUSER_WIDTH  input sideband.
- s_axi4s_tlast  in  1  input end-of-line.
- s_axi4s_tdata  in  S_TDATA_WIDTH  packed class scores.
- s_axi4s_tvalid  in  1  input valid.
- s_axi4s_tready  out  1  input ready.
- m_axi4s_tuser  out  TUSER_WIDTH  delayed copy of the input tuser.
- m_axi4s_tlast  out  1  delayed copy of the input tlast.
- m_axi4s_tclass  out  CLASS_WIDTH  argmax class index, 0..9.
- m_axi4s_tscore  out  SCORE_WIDTH  score of the winning class.
- m_axi4s_tdetect  out  1  1 when tscore >= the active threshold.
- m_axi4s_tvalid  out  1  output valid.
- m_axi4s_tready  in  1  output ready.

## Operation
- Five-stage pipeline. Each stage holds a valid bit, tuser, tlast, and candidate (index, score) pairs.
  - S1: compare pairs (0,1), (2,3), (4,5), (6,7), (8,9), giving 5 candidates.
  - S2: compare (c0,c1) and (c2,c3); pass c4 through. Gives 3 candidates.
  - S3: compare (d0,d1); pass d2 through. Gives 2 candidates.
  - S4: compare the final pair, giving 1 winner.
  - S5: threshold compare and output register.
- Compare rule: the higher-index candidate wins only if its score is strictly greater. Ties therefore resolve to the lowest class index.
- Scores are unsigned with no arithmetic growth; comparisons are SCORE_WIDTH-bit unsigned.
- Threshold capture:
  - The active threshold register loads param_threshold on every accepted input beat with tuser[0]=1.
  - That loaded value travels with the beat down the pipeline, so every beat uses the threshold of its own frame.
  - Changes to param_threshold mid-frame have no effect until the next start-of-frame beat is accepted.
  - The active threshold resets to 0, so detect=1 for any beat before the first start-of-frame.
- Flow control:
  - Global pipeline enable cke = !m_axi4s_tvalid | m_axi4s_tready.
  - s_axi4s_tready = cke.
  - All stages advance together when cke=1 and hold when cke=0.
  - Bubbles (tvalid=0 beats) propagate as invalid stage entries and are never emitted.
- tuser and tlast pass through unchanged and stay aligned with their own data beat.
- Beat order is preserved. No beat is dropped or duplicated.

## Timing
- Latency: 5 cycles from input acceptance to m_axi4s_tvalid=1, when m_axi4s_tready is held high.
- Throughput: 1 beat per cycle sustained.
- Reset: when aresetn=0 at a clock edge, all stage valid bits, m_axi4s_tvalid, tuser, tlast, tclass, tscore, tdetect and the active threshold clear to 0 at that edge.
- s_axi4s_tready is 1 in the cycle after reset, since output valid is 0.
- Reset mid-operation discards every in-flight beat; nothing from before reset is emitted afterwards.
- Output stability: while m_axi4s_tvalid=1 and m_axi4s_tready=0, all m_* outputs hold stable and s_axi4s_tready=0.
- Simultaneous events: a start-of-frame beat accepted in the same cycle param_threshold changes captures the new value.
- The output register accepts a new beat in the same cycle the current one is consumed (tvalid=1 and tready=1).
- No combinational path from s_axi4s_tvalid to any m_* output.
- s_axi4s_tready depends combinationally only on m_axi4s_tvalid and m_axi4s_tready.

## Test plan
- Threshold detect: threshold 100; start-of-frame beat with class3=200 and all others 10.
  - Exactly 5 cycles later: tclass=3, tscore=200, tdetect=1, tuser=1.
- Tie: class2=50 and class7=50, all others 0, threshold 0.
  - tclass=2, tscore=50, tdetect=1.
- Below threshold: all scores 20, threshold 100.
  - tclass=0, tscore=20, tdetect=0.
  - A 9-beat line with tlast on beat 9 emits tlast only on output beat 9.
- Backpressure: 12 back-to-back beats with class = beat%10; m_axi4s_tready=0 for 7 cycles mid-stream.
  - 12 outputs in order, with no loss or duplication.
  - s_axi4s_tready=0 and outputs frozen throughout the stall.
- Threshold change mid-frame: frame A at threshold 100, param changed to 30 at beat 3.
  - A beat with max 50 inside frame A gives detect=0.
  - The same data after frame B's start-of-frame gives detect=1.
- Reset mid-operation: aresetn=0 for 1 cycle with 3 beats in flight.
  - m_axi4s_tvalid=0 from the next edge.
  - None of the 3 beats is ever emitted.
  - The next accepted beat appears 5 cycles later.
